// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the 4-register ALU core.
// Optional single-step support (PAUSE state, step_mode/step) is built when SEQ_STEP_EN is defined.
module core_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        stop,
  input  logic        step_mode,
  input  logic        step,
  input  logic [19:0] instr_in,
  output logic [19:0] ir,
  output logic        pc_inc,
  output logic        wr_en,
  output logic [1:0]  wr_addr,
  output logic        busy,
  output logic        halted,
  output logic        idx_err,
  output logic [15:0] instr_count
);

  localparam logic [3:0] OP_NULL = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
`ifdef SEQ_STEP_EN
    S_PAUSE,
`endif
    S_HALTED
  } state_t;

  state_t state, state_n;
  logic   busy_n, halted_n;
  logic   bad_idx, is_null;

`ifndef SEQ_STEP_EN
  logic unused_step;
  assign unused_step = step_mode | step;
`endif

  assign bad_idx = (ir[15:8] > 8'd3);
  assign is_null = (ir[19:16] == OP_NULL);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (run) state_n = S_FETCH;
      S_FETCH:     state_n = S_DECODE;
      S_DECODE: begin
        if (ir[19:16] == OP_HALT)  state_n = S_HALTED;
        else if (is_null)          state_n = S_WRITEBACK;
        else                       state_n = S_EXECUTE;
      end
      S_EXECUTE:   state_n = S_WRITEBACK;
      S_WRITEBACK: begin
        if (stop)            state_n = S_IDLE;
`ifdef SEQ_STEP_EN
        else if (step_mode)  state_n = S_PAUSE;
`endif
        else                 state_n = S_FETCH;
      end
`ifdef SEQ_STEP_EN
      S_PAUSE: begin
        if (stop)       state_n = S_IDLE;
        else if (step)  state_n = S_FETCH;
      end
`endif
      S_HALTED:    state_n = S_HALTED;
      default:     state_n = S_IDLE;
    endcase
  end

  // busy/halted are registered copies of the next-state decode so they track state exactly
  always_comb begin
    busy_n   = 1'b0;
    halted_n = 1'b0;
    case (state_n)
      S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK: busy_n = 1'b1;
`ifdef SEQ_STEP_EN
      S_PAUSE:  busy_n = 1'b1;
`endif
      S_HALTED: halted_n = 1'b1;
      default:  ;
    endcase
  end

  assign pc_inc  = (state == S_WRITEBACK);
  assign wr_en   = pc_inc && !is_null && !bad_idx;
  assign wr_addr = ir[9:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ir          <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      idx_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      state  <= state_n;
      busy   <= busy_n;
      halted <= halted_n;
      if (state == S_FETCH)
        ir <= instr_in;
      if (state == S_DECODE && bad_idx)
        idx_err <= 1'b1;
      if (state == S_WRITEBACK)
        instr_count <= instr_count + 16'd1;
    end
  end

endmodule
